branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Parametrised branch unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters.
//  Fetch side: looks up F_PC and supplies predicted direction/target.
//  Execute side: resolves branch/JAL/JALR, flags mispredicts with the corrected PC, trains the table.
//  Sits between the IF PC mux and the EX stage; replaces the non-predicting EX-only branch resolve.
// PARAMETERS
//  PC_W     9   PC width in bits; PCs are zero-extended to 32 on all 32-bit outputs
//  ENTRIES  16  BTB entries; power of 2, 2..2^(PC_W-2)
//  STAT_W   16  width of statistics counters (BPU_STATS_EN only)
//  Derived: IDX_W=$clog2(ENTRIES); index=PC[IDX_W+1:2]; tag=PC[PC_W-1:IDX_W+2]
// PORTS
//  clk            in   1     clock, all state on rising edge
//  reset          in   1     asynchronous, active-low reset
//  F_PC           in   PC_W  fetch PC to look up
//  F_PredTaken    out  1     predicted taken for F_PC
//  F_PredPC       out  32    predicted next PC (target if taken, else F_PC+4)
//  E_Valid        in   1     EX-stage instruction valid (not bubble/flushed)
//  E_PC           in   PC_W  PC of EX instruction
//  E_Imm          in   32    immediate
//  E_Branch       in   1     conditional branch
//  E_JSel         in   1     JAL
//  E_JalrSel      in   1     JALR
//  E_AluResult    in   32    ALU result: bit0=condition (branch), jump address (JALR)
//  E_PredTaken    in   1     prediction piped from fetch with this instruction
//  E_PredPC       in   32    predicted next PC piped from fetch
//  PC_Imm         out  32    JalrSel ? (E_AluResult & ~32'h1) : E_PC+E_Imm
//  PC_Four        out  32    E_PC+4
//  BrPC           out  32    corrected next PC: actual taken ? PC_Imm : PC_Four
//  PcSel          out  1     redirect fetch to BrPC and flush younger stages (=Mispredict)
//  Mispredict     out  1     prediction wrong for valid EX instruction
// BEHAVIOUR
//  Entry: valid, tag[PC_W-IDX_W-2], target[PC_W], cnt[2]. Reset (async): all valid=0, cnt=2'b01, stats=0.
//  Lookup (comb.): hit=valid[idx]&&tag match; F_PredTaken=hit&&cnt[1]; F_PredPC={0,target} else F_PC+4.
//  Resolve (comb., same cycle): taken_a = E_JSel|E_JalrSel|(E_Branch&E_AluResult[0]); tgt_a=PC_Imm.
//  Mispredict = E_Valid && (E_PredTaken!=taken_a || (taken_a && E_PredPC!=tgt_a)); 32-bit compare.
//  E_Valid=0: Mispredict=PcSel=0, no table update; PC_Imm/PC_Four/BrPC still computed.
//  Sums wrap modulo 2^32; stored target = tgt_a[PC_W-1:0] (out-of-range targets always mispredict).
//  Update on clk edge when E_Valid and control instr (Branch|JSel|JalrSel):
//   hit on E_PC: branch taken -> cnt sat-inc (max 11), not taken -> sat-dec (min 00);
//     jump -> cnt=11; if taken, target<=tgt_a.
//   miss & taken_a: allocate/overwrite idx: valid=1, tag, target=tgt_a, cnt=10 (branch) / 11 (jump).
//   miss & not taken: no change.
//  E_Valid and non-control instr with hit (alias): entry invalidated; Mispredict per rule above.
//  Same-cycle lookup and update of one index: lookup returns pre-update contents (no bypass).
//  Reset asserted mid-operation: table cleared immediately; F_PredTaken=0 while reset low.
//  Latency: prediction 0 cycles, resolve 0 cycles, training visible to lookups 1 cycle after edge.
// CONFIGURATION
//  BPU_STATS_EN defined: adds out ports StatBranches[STAT_W], StatMispredicts[STAT_W];
//   StatBranches +1 per valid control instr, StatMispredicts +1 per Mispredict; saturate at all-ones.
//  BPU_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING (PC_W=9, ENTRIES=16)
//  Post-reset F_PC=0x040 -> F_PredTaken=0, F_PredPC=0x044.
//  Branch E_PC=0x040, Imm=0x20, AluResult=1, PredTaken=0, PredPC=0x44 -> Mispredict=1, BrPC=0x060;
//   next cycle F_PC=0x040 -> F_PredTaken=1, F_PredPC=0x060 (cnt=10).
//  Same branch not taken 3x (PredTaken per table) -> cnt 10->01->00->00; 1st Mispredict, BrPC=0x044.
//  JALR E_PC=0x080, AluResult=0x0A5 -> BrPC=0x0A4, cnt=11; again with 0x0C1, PredPC=0x0A4 -> Mispredict, BrPC=0x0C0, target=0x0C0.
//  Train 0x040 taken; F_PC=0x140 (same idx, tag differs) -> F_PredTaken=0; E_Valid=0 with bad pred -> PcSel=0.
//  Trained table, pulse reset low mid-cycle -> F_PredTaken=0 at once; stats=0 (BPU_STATS_EN).

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with 2-bit saturating counters.
// The fetch side predicts from F_PC combinationally. The execute side resolves
// branches, JAL and JALR in the same cycle, flags mispredicts with the corrected
// PC, and trains the table on the clock edge.
// Optional build macro BPU_STATS_EN adds the saturating statistics counters
// StatBranches and StatMispredicts.
module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   F_PC,
    output logic              F_PredTaken,
    output logic [31:0]       F_PredPC,
    input  logic              E_Valid,
    input  logic [PC_W-1:0]   E_PC,
    input  logic [31:0]       E_Imm,
    input  logic              E_Branch,
    input  logic              E_JSel,
    input  logic              E_JalrSel,
    input  logic [31:0]       E_AluResult,
    input  logic              E_PredTaken,
    input  logic [31:0]       E_PredPC,
    output logic [31:0]       PC_Imm,
    output logic [31:0]       PC_Four,
    output logic [31:0]       BrPC,
    output logic              PcSel,
    output logic              Mispredict
`ifdef BPU_STATS_EN
    ,
    output logic [STAT_W-1:0] StatBranches,
    output logic [STAT_W-1:0] StatMispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    // A table covering the whole PC space has no tag bits; a constant 1-bit
    // tag keeps the storage legal and always matches.
    localparam int TAG_S = (TAG_W > 0) ? TAG_W : 1;

    function automatic logic [IDX_W-1:0] idx_of(input logic [PC_W-1:0] pc);
        return IDX_W'(pc >> 2);
    endfunction

    function automatic logic [TAG_S-1:0] tag_of(input logic [PC_W-1:0] pc);
        return TAG_S'(pc >> (IDX_W + 2));
    endfunction

    logic             valid_q [ENTRIES];
    logic [TAG_S-1:0] tag_q   [ENTRIES];
    logic [PC_W-1:0]  tgt_q   [ENTRIES];
    logic [1:0]       cnt_q   [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_S-1:0] f_tag;
    logic             f_hit;
    logic [31:0]      f_pc32;

    logic [IDX_W-1:0] e_idx;
    logic [TAG_S-1:0] e_tag;
    logic             e_hit;
    logic             e_ctrl;
    logic             e_jump;
    logic             taken_a;
    logic [31:0]      e_pc32;

    logic             upd_en;
    logic             upd_valid;
    logic [TAG_S-1:0] upd_tag;
    logic [PC_W-1:0]  upd_tgt;
    logic [1:0]       upd_cnt;

    // Fetch-side lookup; the table is read before any same-cycle update lands
    always_comb begin
        f_idx       = idx_of(F_PC);
        f_tag       = tag_of(F_PC);
        f_pc32      = 32'(F_PC);
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        F_PredTaken = f_hit && cnt_q[f_idx][1];
        F_PredPC    = F_PredTaken ? 32'(tgt_q[f_idx]) : f_pc32 + 32'd4;
    end

    // Execute-side resolve: actual direction/target and mispredict detection
    always_comb begin
        e_pc32     = 32'(E_PC);
        e_ctrl     = E_Branch | E_JSel | E_JalrSel;
        e_jump     = E_JSel | E_JalrSel;
        taken_a    = e_jump | (E_Branch & E_AluResult[0]);
        PC_Imm     = E_JalrSel ? (E_AluResult & ~32'h1) : e_pc32 + E_Imm;
        PC_Four    = e_pc32 + 32'd4;
        BrPC       = taken_a ? PC_Imm : PC_Four;
        Mispredict = E_Valid &&
                     ((E_PredTaken != taken_a) || (taken_a && (E_PredPC != PC_Imm)));
        PcSel      = Mispredict;
    end

    // Training decision for the entry indexed by E_PC
    always_comb begin
        e_idx     = idx_of(E_PC);
        e_tag     = tag_of(E_PC);
        e_hit     = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
        upd_en    = 1'b0;
        upd_valid = valid_q[e_idx];
        upd_tag   = tag_q[e_idx];
        upd_tgt   = tgt_q[e_idx];
        upd_cnt   = cnt_q[e_idx];
        if (E_Valid && e_ctrl) begin
            if (e_hit) begin
                upd_en = 1'b1;
                if (e_jump) begin
                    upd_cnt = 2'b11;
                end else if (taken_a) begin
                    if (cnt_q[e_idx] != 2'b11) upd_cnt = cnt_q[e_idx] + 2'd1;
                end else begin
                    if (cnt_q[e_idx] != 2'b00) upd_cnt = cnt_q[e_idx] - 2'd1;
                end
                if (taken_a) upd_tgt = PC_Imm[PC_W-1:0];
            end else if (taken_a) begin
                upd_en    = 1'b1;
                upd_valid = 1'b1;
                upd_tag   = e_tag;
                upd_tgt   = PC_Imm[PC_W-1:0];
                upd_cnt   = e_jump ? 2'b11 : 2'b10;
            end
        end else if (E_Valid && e_hit) begin
            // A non-control instruction aliasing onto an entry evicts it
            upd_en    = 1'b1;
            upd_valid = 1'b0;
        end
    end

    // BTB storage with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= 2'b01;
            end
        end else if (upd_en) begin
            valid_q[e_idx] <= upd_valid;
            tag_q[e_idx]   <= upd_tag;
            tgt_q[e_idx]   <= upd_tgt;
            cnt_q[e_idx]   <= upd_cnt;
        end
    end

`ifdef BPU_STATS_EN
    // Saturating counts of resolved control instructions and mispredicts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StatBranches    <= '0;
            StatMispredicts <= '0;
        end else begin
            if (E_Valid && e_ctrl && (StatBranches != '1))
                StatBranches <= StatBranches + 1'b1;
            if (Mispredict && (StatMispredicts != '1))
                StatMispredicts <= StatMispredicts + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (PC_W=9, ENTRIES=16, default build).
module tb_branch_predict_unit;

    logic        clk;
    logic        reset;
    logic [8:0]  F_PC;
    logic        F_PredTaken;
    logic [31:0] F_PredPC;
    logic        E_Valid;
    logic [8:0]  E_PC;
    logic [31:0] E_Imm;
    logic        E_Branch;
    logic        E_JSel;
    logic        E_JalrSel;
    logic [31:0] E_AluResult;
    logic        E_PredTaken;
    logic [31:0] E_PredPC;
    logic [31:0] PC_Imm;
    logic [31:0] PC_Four;
    logic [31:0] BrPC;
    logic        PcSel;
    logic        Mispredict;

    int tests = 0;
    int fails = 0;

    branch_predict_unit #(.PC_W(9), .ENTRIES(16), .STAT_W(16)) dut (
        .clk(clk), .reset(reset), .F_PC(F_PC), .F_PredTaken(F_PredTaken),
        .F_PredPC(F_PredPC), .E_Valid(E_Valid), .E_PC(E_PC), .E_Imm(E_Imm),
        .E_Branch(E_Branch), .E_JSel(E_JSel), .E_JalrSel(E_JalrSel),
        .E_AluResult(E_AluResult), .E_PredTaken(E_PredTaken), .E_PredPC(E_PredPC),
        .PC_Imm(PC_Imm), .PC_Four(PC_Four), .BrPC(BrPC), .PcSel(PcSel),
        .Mispredict(Mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ex(input logic v, input logic br, input logic jal, input logic jalr,
                      input logic [8:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                      input logic pt, input logic [31:0] ppc);
        E_Valid = v; E_Branch = br; E_JSel = jal; E_JalrSel = jalr;
        E_PC = pc; E_Imm = imm; E_AluResult = alu; E_PredTaken = pt; E_PredPC = ppc;
    endtask

    task automatic idle();
        ex(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b0; idle(); F_PC = 9'h040;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1; #1;
        tests++; if (F_PredTaken !== 1'b0) begin fails++; $display("FAIL reset_pred_taken: got %0b want 0", F_PredTaken); end
        tests++; if (F_PredPC !== 32'h44) begin fails++; $display("FAIL reset_pred_pc: got %h want 00000044", F_PredPC); end
        tests++; if (Mispredict !== 1'b0) begin fails++; $display("FAIL reset_mispredict: got %0b want 0", Mispredict); end
    endtask

    task automatic test_branch_taken();
        @(negedge clk); F_PC = 9'h040; ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h1, 0, 32'h44); #1;
        tests++; if (Mispredict !== 1'b1) begin fails++; $display("FAIL bt_mispredict: got %0b want 1", Mispredict); end
        tests++; if (PcSel !== 1'b1) begin fails++; $display("FAIL bt_pcsel: got %0b want 1", PcSel); end
        tests++; if (BrPC !== 32'h60) begin fails++; $display("FAIL bt_brpc: got %h want 00000060", BrPC); end
        tests++; if (PC_Imm !== 32'h60) begin fails++; $display("FAIL bt_pcimm: got %h want 00000060", PC_Imm); end
        tests++; if (PC_Four !== 32'h44) begin fails++; $display("FAIL bt_pcfour: got %h want 00000044", PC_Four); end
        tests++; if (F_PredTaken !== 1'b0) begin fails++; $display("FAIL bt_no_bypass: got %0b want 0", F_PredTaken); end
        @(negedge clk); idle(); #1;
        tests++; if (F_PredTaken !== 1'b1) begin fails++; $display("FAIL bt_trained_taken: got %0b want 1", F_PredTaken); end
        tests++; if (F_PredPC !== 32'h60) begin fails++; $display("FAIL bt_trained_pc: got %h want 00000060", F_PredPC); end
    endtask

    task automatic test_branch_saturation();
        // cnt 10 -> 01 (mispredict), 01 -> 00, 00 -> 00
        @(negedge clk); ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h0, 1, 32'h60); #1;
        tests++; if (Mispredict !== 1'b1) begin fails++; $display("FAIL nt1_mispredict: got %0b want 1", Mispredict); end
        tests++; if (BrPC !== 32'h44) begin fails++; $display("FAIL nt1_brpc: got %h want 00000044", BrPC); end
        @(negedge clk); idle(); #1;
        tests++; if (F_PredTaken !== 1'b0) begin fails++; $display("FAIL nt1_pred: got %0b want 0", F_PredTaken); end
        tests++; if (F_PredPC !== 32'h44) begin fails++; $display("FAIL nt1_predpc: got %h want 00000044", F_PredPC); end
        @(negedge clk); ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h0, 0, 32'h44); #1;
        tests++; if (Mispredict !== 1'b0) begin fails++; $display("FAIL nt2_mispredict: got %0b want 0", Mispredict); end
        @(negedge clk); ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h0, 0, 32'h44); #1;
        tests++; if (Mispredict !== 1'b0) begin fails++; $display("FAIL nt3_mispredict: got %0b want 0", Mispredict); end
        // 00 -> 01 stays not-taken; 01 -> 10 becomes taken
        @(negedge clk); ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h1, 0, 32'h44); #1;
        tests++; if (Mispredict !== 1'b1) begin fails++; $display("FAIL t4_mispredict: got %0b want 1", Mispredict); end
        @(negedge clk); idle(); #1;
        tests++; if (F_PredTaken !== 1'b0) begin fails++; $display("FAIL sat_floor_pred: got %0b want 0", F_PredTaken); end
        @(negedge clk); ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h1, 0, 32'h44);
        @(negedge clk); idle(); #1;
        tests++; if (F_PredTaken !== 1'b1) begin fails++; $display("FAIL t5_pred: got %0b want 1", F_PredTaken); end
    endtask

    task automatic test_jalr();
        @(negedge clk); F_PC = 9'h080; ex(1, 0, 0, 1, 9'h080, 32'h0, 32'h0A5, 0, 32'h84); #1;
        tests++; if (Mispredict !== 1'b1) begin fails++; $display("FAIL jalr1_mispredict: got %0b want 1", Mispredict); end
        tests++; if (PC_Imm !== 32'hA4) begin fails++; $display("FAIL jalr1_pcimm: got %h want 000000a4", PC_Imm); end
        tests++; if (BrPC !== 32'hA4) begin fails++; $display("FAIL jalr1_brpc: got %h want 000000a4", BrPC); end
        @(negedge clk); idle(); #1;
        tests++; if (F_PredTaken !== 1'b1) begin fails++; $display("FAIL jalr1_pred: got %0b want 1", F_PredTaken); end
        tests++; if (F_PredPC !== 32'hA4) begin fails++; $display("FAIL jalr1_predpc: got %h want 000000a4", F_PredPC); end
        F_PC = 9'h040; #1;
        tests++; if (F_PredTaken !== 1'b0) begin fails++; $display("FAIL jalr_evict_pred: got %0b want 0", F_PredTaken); end
        @(negedge clk); F_PC = 9'h080; ex(1, 0, 0, 1, 9'h080, 32'h0, 32'h0C1, 1, 32'hA4); #1;
        tests++; if (Mispredict !== 1'b1) begin fails++; $display("FAIL jalr2_mispredict: got %0b want 1", Mispredict); end
        tests++; if (BrPC !== 32'hC0) begin fails++; $display("FAIL jalr2_brpc: got %h want 000000c0", BrPC); end
        @(negedge clk); idle(); #1;
        tests++; if (F_PredPC !== 32'hC0) begin fails++; $display("FAIL jalr2_predpc: got %h want 000000c0", F_PredPC); end
        @(negedge clk); ex(1, 0, 0, 1, 9'h080, 32'h0, 32'h0C0, 1, 32'hC0); #1;
        tests++; if (Mispredict !== 1'b0) begin fails++; $display("FAIL jalr3_mispredict: got %0b want 0", Mispredict); end
        tests++; if (PcSel !== 1'b0) begin fails++; $display("FAIL jalr3_pcsel: got %0b want 0", PcSel); end
    endtask

    task automatic test_jal_wrap();
        @(negedge clk); F_PC = 9'h004; ex(1, 0, 1, 0, 9'h004, 32'hFFFF_FFF0, 32'h0, 0, 32'h8); #1;
        tests++; if (BrPC !== 32'hFFFF_FFF4) begin fails++; $display("FAIL jal_wrap_brpc: got %h want fffffff4", BrPC); end
        tests++; if (Mispredict !== 1'b1) begin fails++; $display("FAIL jal_wrap_mispredict: got %0b want 1", Mispredict); end
        @(negedge clk); idle(); #1;
        tests++; if (F_PredPC !== 32'h1F4) begin fails++; $display("FAIL jal_trunc_predpc: got %h want 000001f4", F_PredPC); end
        @(negedge clk); ex(1, 0, 1, 0, 9'h004, 32'hFFFF_FFF0, 32'h0, 1, 32'h1F4); #1;
        tests++; if (Mispredict !== 1'b1) begin fails++; $display("FAIL jal_oor_mispredict: got %0b want 1", Mispredict); end
    endtask

    task automatic test_alias();
        @(negedge clk); F_PC = 9'h140; ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h1, 0, 32'h44); #1;
        tests++; if (Mispredict !== 1'b1) begin fails++; $display("FAIL alias_alloc_mispredict: got %0b want 1", Mispredict); end
        @(negedge clk); idle(); #1;
        tests++; if (F_PredTaken !== 1'b0) begin fails++; $display("FAIL alias_tag_pred: got %0b want 0", F_PredTaken); end
        tests++; if (F_PredPC !== 32'h144) begin fails++; $display("FAIL alias_tag_predpc: got %h want 00000144", F_PredPC); end
        F_PC = 9'h040; #1;
        tests++; if (F_PredTaken !== 1'b1) begin fails++; $display("FAIL alias_own_pred: got %0b want 1", F_PredTaken); end
    endtask

    task automatic test_invalid();
        @(negedge clk); ex(0, 1, 0, 0, 9'h040, 32'h20, 32'h1, 0, 32'h44); #1;
        tests++; if (PcSel !== 1'b0) begin fails++; $display("FAIL inv_pcsel: got %0b want 0", PcSel); end
        tests++; if (BrPC !== 32'h60) begin fails++; $display("FAIL inv_brpc: got %h want 00000060", BrPC); end
        @(negedge clk); ex(0, 1, 0, 0, 9'h040, 32'h20, 32'h0, 1, 32'h60); #1;
        tests++; if (Mispredict !== 1'b0) begin fails++; $display("FAIL inv_mispredict: got %0b want 0", Mispredict); end
        @(negedge clk); ex(0, 1, 0, 0, 9'h040, 32'h20, 32'h0, 1, 32'h60);
        @(negedge clk); idle(); #1;
        tests++; if (F_PredTaken !== 1'b1) begin fails++; $display("FAIL inv_no_train: got %0b want 1", F_PredTaken); end
    endtask

    task automatic test_noncontrol();
        @(negedge clk); ex(1, 0, 0, 0, 9'h040, 32'h20, 32'h1, 1, 32'h60); #1;
        tests++; if (Mispredict !== 1'b1) begin fails++; $display("FAIL nc_mispredict: got %0b want 1", Mispredict); end
        tests++; if (BrPC !== 32'h44) begin fails++; $display("FAIL nc_brpc: got %h want 00000044", BrPC); end
        @(negedge clk); idle(); #1;
        tests++; if (F_PredTaken !== 1'b0) begin fails++; $display("FAIL nc_invalidate: got %0b want 0", F_PredTaken); end
        @(negedge clk); ex(1, 0, 0, 0, 9'h040, 32'h20, 32'h1, 0, 32'h44); #1;
        tests++; if (Mispredict !== 1'b0) begin fails++; $display("FAIL nc_correct: got %0b want 0", Mispredict); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); ex(1, 1, 0, 0, 9'h040, 32'h20, 32'h1, 0, 32'h44);
        @(negedge clk); idle(); #1;
        tests++; if (F_PredTaken !== 1'b1) begin fails++; $display("FAIL rm_pretrain: got %0b want 1", F_PredTaken); end
        #2 reset = 1'b0; #1;
        tests++; if (F_PredTaken !== 1'b0) begin fails++; $display("FAIL rm_async_pred: got %0b want 0", F_PredTaken); end
        tests++; if (F_PredPC !== 32'h44) begin fails++; $display("FAIL rm_async_predpc: got %h want 00000044", F_PredPC); end
        @(negedge clk); reset = 1'b1; #1;
        tests++; if (F_PredTaken !== 1'b0) begin fails++; $display("FAIL rm_after_release: got %0b want 0", F_PredTaken); end
        F_PC = 9'h004; #1;
        tests++; if (F_PredTaken !== 1'b0) begin fails++; $display("FAIL rm_other_entry: got %0b want 0", F_PredTaken); end
    endtask

    initial begin
        test_reset();
        test_branch_taken();
        test_branch_saturation();
        test_jalr();
        test_jal_wrap();
        test_alias();
        test_invalid();
        test_noncontrol();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
